// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the mpmc11 memory controller.
package mpmc11_pkg;

    typedef enum logic [2:0] {
        FILL_IDLE      = 3'd0,
        FILL_PRESET    = 3'd1,
        FILL_ISSUE     = 3'd2,
        FILL_WAIT_DATA = 3'd3,
        FILL_DONE      = 3'd4
    } mpmc11_fill_state_t;

    localparam logic [2:0] MPMC11_CMD_READ = 3'b001;

endpackage

// File: rtl/mpmc11_fill_cnt.sv
// Beat counter for cache fills: masks beats beyond burst_len and drives the
// zero-latency cache write strobe and beat index.
module mpmc11_fill_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       count_en,
    input  logic       data_valid,
    input  logic [7:0] burst_len,
    output logic       fill_we,
    output logic [7:0] fill_cnt,
    output logic       last_beat
);

    // 9 bits so a 256-beat fill (burst_len=255) ends at 256 without wrapping
    logic [8:0] beat_cnt;

    always_comb begin
        fill_we   = count_en && data_valid && (beat_cnt <= {1'b0, burst_len});
        last_beat = fill_we && (beat_cnt == {1'b0, burst_len});
        fill_cnt  = beat_cnt[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat_cnt <= '0;
        end else if (fill_we) begin
            beat_cnt <= beat_cnt + 9'd1;
        end
    end

endmodule

// File: rtl/mpmc11_fill_seq.sv
// Cache-fill read sequencer: issues 32-byte read commands and counts returning beats.
// Optional idle timeout abort is compiled in with MPMC11_FILL_TIMEOUT_EN.
module mpmc11_fill_seq
    import mpmc11_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [31:0]        req_addr,
    input  logic [7:0]         req_burst_len,
    output logic               ack,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output mpmc11_fill_state_t state,
    output logic               app_en,
    output logic [2:0]         app_cmd,
    output logic [31:0]        app_addr,
    input  logic               app_rdy,
    input  logic               app_rd_data_valid,
    output logic               fill_we,
    output logic [7:0]         fill_cnt
);

    mpmc11_fill_state_t next_state;
    logic [7:0] burst_len;
    logic [8:0] cmd_cnt;
    logic       count_en;
    logic       accept;
    logic       cmd_last;
    logic       last_beat;
    logic       timeout_hit;
    logic       ack_nxt, busy_nxt, done_nxt, app_en_nxt;
    logic [6:0] unused_addr_bits;

    assign unused_addr_bits = {req_addr[31:30], req_addr[4:0]};

    assign count_en = (state == FILL_ISSUE) || (state == FILL_WAIT_DATA);
    assign accept   = app_en && app_rdy;
    assign cmd_last = (cmd_cnt == {1'b0, burst_len});

`ifdef MPMC11_FILL_TIMEOUT_EN
    logic [31:0] idle_cnt;
    assign timeout_hit = count_en && !fill_we && ((idle_cnt + 32'd1) == TIMEOUT_CYCLES);
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    mpmc11_fill_cnt u_fill_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == FILL_PRESET),
        .count_en   (count_en),
        .data_valid (app_rd_data_valid),
        .burst_len  (burst_len),
        .fill_we    (fill_we),
        .fill_cnt   (fill_cnt),
        .last_beat  (last_beat)
    );

    always_comb begin
        next_state = state;
        case (state)
            FILL_IDLE:      if (req) next_state = FILL_PRESET;
            FILL_PRESET:    next_state = FILL_ISSUE;
            FILL_ISSUE: begin
                if (last_beat || timeout_hit)  next_state = FILL_DONE;
                else if (accept && cmd_last)   next_state = FILL_WAIT_DATA;
            end
            FILL_WAIT_DATA: if (last_beat || timeout_hit) next_state = FILL_DONE;
            FILL_DONE:      next_state = FILL_IDLE;
            default:        next_state = FILL_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered
    always_comb begin
        ack_nxt    = (next_state == FILL_PRESET);
        busy_nxt   = (next_state != FILL_IDLE);
        done_nxt   = (next_state == FILL_DONE);
        app_en_nxt = (next_state == FILL_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL_IDLE;
            ack         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            app_en      <= 1'b0;
            app_cmd     <= '0;
            app_addr    <= '0;
            burst_len   <= '0;
            cmd_cnt     <= '0;
`ifdef MPMC11_FILL_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            state       <= next_state;
            ack         <= ack_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            timeout_err <= timeout_hit;
            app_en      <= app_en_nxt;
            app_cmd     <= app_en_nxt ? MPMC11_CMD_READ : 3'b000;
            case (state)
                FILL_IDLE: begin
                    if (req) begin
                        app_addr  <= {2'b00, req_addr[29:5], 5'h00};
                        burst_len <= req_burst_len;
                    end
                end
                FILL_PRESET: cmd_cnt <= '0;
                FILL_ISSUE: begin
                    if (accept) begin
                        app_addr <= {2'b00, app_addr[29:5] + 25'd1, 5'h00};
                        cmd_cnt  <= cmd_cnt + 9'd1;
                    end
                end
                default: ;
            endcase
`ifdef MPMC11_FILL_TIMEOUT_EN
            if (state == FILL_PRESET || fill_we) begin
                idle_cnt <= '0;
            end else if (count_en) begin
                idle_cnt <= idle_cnt + 32'd1;
            end
`endif
        end
    end

endmodule
